// File: rtl/fetch_stage.sv
// PC register and instruction-fetch controller: fetches over req/ack, buffers one
// instruction for decode over valid/ready, and handles flush, misalignment, bus errors and timeouts.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] next_pc,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic [31:0] current_pc,
   output logic [31:0] pc_4,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        imem_err,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic [1:0]  inst_fault,
   output logic [1:0]  state_dbg
);

   // Decode handshake: an instruction transfers on the rising edge where inst_valid and
   // inst_ready are both high; inst_valid never drops and inst/inst_pc/inst_fault never
   // change until that edge, unless a flush discards the buffered instruction.
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT - 1);

   localparam logic [1:0] F_NONE     = 2'b00;
   localparam logic [1:0] F_MISALIGN = 2'b01;
   localparam logic [1:0] F_BUS      = 2'b10;
   localparam logic [1:0] F_TIMEOUT  = 2'b11;

   state_t        state_q;
   logic [31:0]   pc_q;
   logic [31:0]   addr_q;
   logic [CW-1:0] cnt_q;
   logic          req_active;
   logic          cnt_done;

   // A request is live in DRAIN (stale) or in FETCH with an aligned PC.
   assign req_active = (state_q == DRAIN) || ((state_q == FETCH) && (pc_q[1:0] == 2'b00));
   assign cnt_done   = (cnt_q == TO_MAX);

   assign imem_req   = rst_n & req_active;
   assign imem_addr  = addr_q;
   assign current_pc = pc_q;
   assign pc_4       = pc_q + 32'd4;
   assign state_dbg  = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         addr_q     <= RESET_PC;
         cnt_q      <= '0;
         inst_valid <= 1'b0;
         inst       <= 32'h0;
         inst_pc    <= 32'h0;
         inst_fault <= F_NONE;
      end else if (flush) begin
         pc_q       <= flush_pc;
         inst_valid <= 1'b0;
         // A request still waiting for its ack must be drained before refetching.
         if ((state_q != HOLD) && req_active && !imem_ack) begin
            state_q <= DRAIN;
            if (!cnt_done) cnt_q <= cnt_q + CW'(1);
         end else begin
            state_q <= FETCH;
            addr_q  <= flush_pc;
            cnt_q   <= '0;
         end
      end else begin
         case (state_q)
            FETCH: begin
               if (pc_q[1:0] != 2'b00) begin
                  state_q    <= HOLD;
                  inst_valid <= 1'b1;
                  inst       <= 32'h0;
                  inst_pc    <= pc_q;
                  inst_fault <= F_MISALIGN;
               end else if (imem_ack) begin
                  state_q    <= HOLD;
                  inst_valid <= 1'b1;
                  inst       <= imem_err ? 32'h0 : imem_rdata;
                  inst_pc    <= pc_q;
                  inst_fault <= imem_err ? F_BUS : F_NONE;
               end else if (cnt_done) begin
                  state_q    <= HOLD;
                  inst_valid <= 1'b1;
                  inst       <= 32'h0;
                  inst_pc    <= pc_q;
                  inst_fault <= F_TIMEOUT;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            HOLD: begin
               if (inst_ready) begin
                  state_q    <= FETCH;
                  pc_q       <= next_pc;
                  addr_q     <= next_pc;
                  cnt_q      <= '0;
                  inst_valid <= 1'b0;
               end
            end
            DRAIN: begin
               // The stale response (or its timeout) is discarded silently.
               if (imem_ack || cnt_done) begin
                  state_q <= FETCH;
                  addr_q  <= pc_q;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               state_q <= FETCH;
               addr_q  <= pc_q;
               cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: scripted memory and decode drivers with a
// scoreboard of expected {fault, pc, inst} entries.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          TIMEOUT  = 16;
   localparam int          W        = 66;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] next_pc;
   logic        flush;
   logic [31:0] flush_pc;
   logic [31:0] current_pc;
   logic [31:0] pc_4;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        imem_err;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [1:0]  inst_fault;
   logic [1:0]  state_dbg;

   logic [W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;

   fetch_stage #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .flush(flush), .flush_pc(flush_pc),
      .current_pc(current_pc), .pc_4(pc_4), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_err(imem_err),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
      .inst_fault(inst_fault), .state_dbg(state_dbg)
   );

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // decode side: accept the buffered instruction and compare with the scoreboard
   task automatic handshake(input logic [31:0] nxt);
      logic [W-1:0] got, exp;
      next_pc    = nxt;
      inst_ready = 1'b1;
      got = {inst_fault, inst_pc, inst};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL inst_out scoreboard empty, got %h", got);
      end else begin
         exp = exp_q.pop_front();
         if (inst_valid !== 1'b1 || imem_req !== 1'b0 || got !== exp) begin
            errors++;
            $display("FAIL inst_out valid=%b req=%b got %h exp %h", inst_valid, imem_req, got, exp);
         end
      end
      tick();
      inst_ready = 1'b0;
      next_pc    = 32'hBAD0_0000;
      checks++;
      if (inst_valid !== 1'b0 || current_pc !== nxt) begin
         errors++;
         $display("FAIL after_hs valid=%b pc=%h exp valid=0 pc=%h", inst_valid, current_pc, nxt);
      end
   endtask

   // memory side: mode 0 ok, 1 bus error, 2 no ack (timeout); then stall decode and accept
   task automatic run_insn(input logic [31:0] pc, input int waits, input int mode,
                           input logic [31:0] data, input int stall, input logic [31:0] nxt);
      logic [W-1:0] got;
      int n_req;
      checks++;
      if (current_pc !== pc || pc_4 !== pc + 32'd4) begin
         errors++;
         $display("FAIL pc_regs pc=%h pc_4=%h exp pc=%h pc_4=%h", current_pc, pc_4, pc, pc + 32'd4);
      end
      n_req = (mode == 2) ? TIMEOUT : waits + 1;
      case (mode)
         0:       exp_q.push_back({2'b00, pc, data});
         1:       exp_q.push_back({2'b10, pc, 32'h0});
         default: exp_q.push_back({2'b11, pc, 32'h0});
      endcase
      for (int i = 0; i < n_req; i++) begin
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== pc || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL req_hold cyc %0d req=%b addr=%h valid=%b exp req=1 addr=%h valid=0",
                     i, imem_req, imem_addr, inst_valid, pc);
         end
         if (i == n_req - 1 && mode != 2) begin
            imem_ack   = 1'b1;
            imem_rdata = data;
            imem_err   = (mode == 1);
         end
         tick();
         imem_ack = 1'b0;
         imem_err = 1'b0;
      end
      for (int i = 0; i < stall; i++) begin
         got = {inst_fault, inst_pc, inst};
         checks++;
         if (inst_valid !== 1'b1 || imem_req !== 1'b0 || got !== exp_q[0]) begin
            errors++;
            $display("FAIL hold_stable valid=%b req=%b got %h exp %h", inst_valid, imem_req, got, exp_q[0]);
         end
         if (mode == 2 && i == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
         end
         tick();
         imem_ack = 1'b0;
      end
      handshake(nxt);
   endtask

   task automatic run_misaligned(input logic [31:0] pc, input logic [31:0] nxt);
      checks++;
      if (current_pc !== pc || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL misalign_noreq pc=%h req=%b exp pc=%h req=0", current_pc, imem_req, pc);
      end
      exp_q.push_back({2'b01, pc, 32'h0});
      imem_ack   = 1'b1;
      imem_rdata = 32'h1234_5678;
      tick();
      imem_ack = 1'b0;
      handshake(nxt);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; flush_pc = 32'h0; next_pc = 32'h0;
      imem_ack = 1'b0; imem_rdata = 32'h0; imem_err = 1'b0; inst_ready = 1'b0;
      tick(); tick();
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 ||
          inst_fault !== 2'b00 || current_pc !== RESET_PC || pc_4 !== RESET_PC + 32'd4 ||
          state_dbg !== 2'd0) begin
         errors++;
         $display("FAIL reset_vals req=%b valid=%b inst=%h ipc=%h flt=%b pc=%h pc4=%h st=%0d exp 0/0/0/0/00/%h/%h/0",
                  imem_req, inst_valid, inst, inst_pc, inst_fault, current_pc, pc_4, state_dbg,
                  RESET_PC, RESET_PC + 32'd4);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
         errors++;
         $display("FAIL first_req req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, RESET_PC);
      end
   endtask

   task automatic test_sequential();
      int start;
      start = cyc;
      run_insn(32'h0, 0, 0, 32'h0000_0013, 0, 32'h4);
      run_insn(32'h4, 0, 0, 32'h0000_0013, 0, 32'h8);
      run_insn(32'h8, 0, 0, 32'h0000_0013, 0, 32'hC);
      checks++;
      if (cyc - start !== 6) begin
         errors++;
         $display("FAIL throughput cycles=%0d exp 6", cyc - start);
      end
   endtask

   task automatic test_backpressure();
      run_insn(32'hC, 3, 0, 32'hA000_0001, 5, 32'h10);
      run_insn(32'h10, $urandom_range(0, 4), 0, $urandom, $urandom_range(0, 3), 32'h14);
      run_insn(32'h14, 0, 0, 32'h0000_0073, 0, 32'h102);
   endtask

   task automatic test_faults();
      run_misaligned(32'h102, 32'h104);
      run_insn(32'h104, 1, 1, 32'hFFFF_0000, 0, 32'h108);
      run_insn(32'h108, 0, 2, 32'h0, 2, 32'h10C);
   endtask

   task automatic test_flush_hold();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10C) begin
         errors++;
         $display("FAIL fh_req req=%b addr=%h exp req=1 addr=0000010c", imem_req, imem_addr);
      end
      imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
      tick();
      imem_ack = 1'b0;
      checks++;
      if (inst_valid !== 1'b1 || inst !== 32'h1111_2222) begin
         errors++;
         $display("FAIL fh_hold valid=%b inst=%h exp valid=1 inst=11112222", inst_valid, inst);
      end
      inst_ready = 1'b1; next_pc = 32'h200; flush = 1'b1; flush_pc = 32'h80;
      tick();
      inst_ready = 1'b0; flush = 1'b0; flush_pc = 32'h0;
      checks++;
      if (inst_valid !== 1'b0 || current_pc !== 32'h80 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin
         errors++;
         $display("FAIL fh_redirect valid=%b pc=%h req=%b addr=%h exp 0/00000080/1/00000080",
                  inst_valid, current_pc, imem_req, imem_addr);
      end
      run_insn(32'h80, 0, 0, 32'h2222_3333, 0, 32'h84);
   endtask

   task automatic test_flush_wait();
      tick();
      flush = 1'b1; flush_pc = 32'h80;
      tick();
      flush = 1'b0; flush_pc = 32'h0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h84 || current_pc !== 32'h80 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_hold req=%b addr=%h pc=%h valid=%b exp 1/00000084/00000080/0",
                     imem_req, imem_addr, current_pc, inst_valid);
         end
         tick();
      end
      imem_ack = 1'b1; imem_rdata = 32'h5555_6666; imem_err = 1'b1;
      tick();
      imem_ack = 1'b0; imem_err = 1'b0;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h80 || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_exit req=%b addr=%h valid=%b exp 1/00000080/0", imem_req, imem_addr, inst_valid);
      end
      run_insn(32'h80, 0, 0, 32'h3333_4444, 0, 32'h88);
   endtask

   task automatic test_wrap();
      run_insn(32'h88, 0, 0, 32'h4444_5555, 0, 32'hFFFF_FFFC);
      checks++;
      if (pc_4 !== 32'h0) begin
         errors++;
         $display("FAIL wrap_pc4 pc_4=%h exp 00000000", pc_4);
      end
      run_insn(32'hFFFF_FFFC, 0, 0, 32'h6666_7777, 0, 32'h0);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL wrap_addr req=%b addr=%h exp req=1 addr=00000000", imem_req, imem_addr);
      end
      run_insn(32'h0, 0, 0, 32'h7777_8888, 0, 32'h4);
   endtask

   task automatic test_async_reset();
      tick();
      flush = 1'b1; flush_pc = 32'h300;
      tick();
      flush = 1'b0; flush_pc = 32'h0;
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0 || current_pc !== RESET_PC || imem_addr !== RESET_PC ||
          inst_fault !== 2'b00 || inst_pc !== 32'h0) begin
         errors++;
         $display("FAIL async_rst req=%b valid=%b pc=%h addr=%h flt=%b ipc=%h exp 0/0/%h/%h/00/0",
                  imem_req, inst_valid, current_pc, imem_addr, inst_fault, inst_pc, RESET_PC, RESET_PC);
      end
      imem_ack = 1'b1; imem_rdata = 32'h9999_AAAA;
      tick(); tick();
      imem_ack = 1'b0;
      rst_n = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== RESET_PC || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_release req=%b addr=%h valid=%b exp 1/%h/0", imem_req, imem_addr, inst_valid, RESET_PC);
      end
      run_insn(RESET_PC, 0, 0, 32'h0000_0013, 0, RESET_PC + 32'd4);
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_backpressure();
      test_faults();
      test_flush_hold();
      test_flush_wait();
      test_wrap();
      test_async_reset();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left=%0d exp 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
